// File: rtl/csa8_pkg.sv
// rtl/csa8_pkg.sv - shared width default and FSM state encoding for the csa8 sequencer
package csa8_pkg;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic [1:0] ST_IDLE_A = 2'd0;
  localparam logic [1:0] ST_LOAD_B = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

endpackage

// File: rtl/csa8_operand_sequencer_if.sv
// rtl/csa8_operand_sequencer_if.sv - operand stream, adder bus and result stream bundle
interface csa8_operand_sequencer_if #(
  parameter int WIDTH = csa8_pkg::WIDTH_DEFAULT
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_acc;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;

  modport master (
    input  in_valid, in_data, in_acc, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, out_valid, out_sum, out_cout, busy
  );

  modport slave (
    output in_valid, in_data, in_acc, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_sum, out_cout, busy
  );
endinterface

// File: rtl/csa8_carry_select_adder.sv
// rtl/csa8_carry_select_adder.sv - 8-bit carry-select adder (ripple low nibble, dual high nibble)
module csa8_carry_select_adder (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);
  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;
  logic [4:0] hi_sel;

  assign lo     = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]};
  assign hi0    = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]};
  assign hi1    = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]} + 5'd1;
  assign hi_sel = lo[4] ? hi1 : hi0;
  assign sum_o  = {hi_sel[3:0], lo[3:0]};
  assign cout_o = hi_sel[4];
endmodule

// File: rtl/csa8_settle_timer.sv
// rtl/csa8_settle_timer.sv - loadable down-counter flagging the last settle edge
module csa8_settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(SETTLE_CYCLES);
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Done while the counter sits at one: the edge that consumes it is the capture edge.
  assign done_o = dec_i && (cnt_q == CW'(1));
endmodule

// File: rtl/csa8_operand_sequencer.sv
// rtl/csa8_operand_sequencer.sv - feeds A/B bytes to an external adder and returns the settled result
module csa8_operand_sequencer
  import csa8_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEFAULT,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  csa8_operand_sequencer_if.master     bus
);
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             timer_load;
  logic             timer_done;

  csa8_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (timer_load),
    .dec_i  (state_q == ST_SETTLE),
    .done_o (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    timer_load = 1'b0;
    case (state_q)
      ST_IDLE_A: begin
        if (bus.in_valid) begin
          if (bus.in_acc) begin
            a_d        = acc_q;
            b_d        = bus.in_data;
            timer_load = 1'b1;
            state_d    = ST_SETTLE;
          end else begin
            a_d     = bus.in_data;
            state_d = ST_LOAD_B;
          end
        end
      end
      ST_LOAD_B: begin
        if (bus.in_valid) begin
          b_d        = bus.in_data;
          timer_load = 1'b1;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // The carry is reported but not folded into the running accumulator.
        if (timer_done) begin
          sum_d   = bus.add_sum;
          cout_d  = bus.add_cout;
          acc_d   = bus.add_sum;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE_A;
        end
      end
      default: state_d = ST_IDLE_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE_A;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE_A) || (state_q == ST_LOAD_B);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.busy      = (state_q != ST_IDLE_A);
  assign bus.add_a     = a_q;
  assign bus.add_b     = b_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
endmodule

// File: tb/tb_csa8_operand_sequencer.sv
// tb/tb_csa8_operand_sequencer.sv - self-checking bench for the sequencer with a carry-select adder
module tb_csa8_operand_sequencer;
  localparam int S = 1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] model_acc;

  always #5 clk = ~clk;

  csa8_operand_sequencer_if #(.WIDTH(8)) bus ();

  csa8_operand_sequencer #(.WIDTH(8), .SETTLE_CYCLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  csa8_carry_select_adder u_adder (
    .a_i    (bus.add_a),
    .b_i    (bus.add_b),
    .sum_o  (bus.add_sum),
    .cout_o (bus.add_cout)
  );

  task automatic send_beat(input logic [7:0] d, input logic acc);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_acc   = acc;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_beat_timeout: in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_acc   = 1'b0;
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic acc,
                       input int delay, input string name);
    logic [7:0] a_exp, s_exp, s_seen;
    logic       c_exp;
    int         sum9;
    int         n;
    a_exp     = acc ? model_acc : a;
    sum9      = int'(a_exp) + int'(b);
    s_exp     = sum9[7:0];
    c_exp     = sum9[8];
    model_acc = s_exp;
    if (!acc) send_beat(a, 1'b0);
    send_beat(b, acc);
    checks++;
    if (bus.add_a !== a_exp || bus.add_b !== b) begin
      errors++;
      $display("FAIL %s_operands: add_a=%h add_b=%h required %h %h", name, bus.add_a, bus.add_b, a_exp, b);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_settle: out_valid=%b in_ready=%b required 0 0", name, bus.out_valid, bus.in_ready);
    end
    repeat (S) begin @(posedge clk); #1; end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency: out_valid=%b required 1", name, bus.out_valid);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    end
    s_seen = bus.out_sum;
    repeat (delay) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== s_seen) begin
        errors++;
        $display("FAIL %s_hold: out_valid=%b out_sum=%h required 1 %h", name, bus.out_valid, bus.out_sum, s_seen);
      end
    end
    checks++;
    if (bus.out_sum !== s_exp || bus.out_cout !== c_exp) begin
      errors++;
      $display("FAIL %s_result: sum=%h cout=%b required %h %b", name, bus.out_sum, bus.out_cout, s_exp, c_exp);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: out_valid=%b busy=%b required 0 0", name, bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_acc = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_acc = 8'h00;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
        bus.add_a !== 8'h00 || bus.add_b !== 8'h00) begin
      errors++;
      $display("FAIL reset: ov=%b ir=%b busy=%b a=%h b=%h required 0 1 0 00 00",
               bus.out_valid, bus.in_ready, bus.busy, bus.add_a, bus.add_b);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_out_ready: busy=%b out_valid=%b required 0 0", bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    do_op(8'h3C, 8'h55, 1'b0, 0, "basic");
  endtask

  task automatic test_carry();
    do_op(8'hFF, 8'h01, 1'b0, 1, "carry");
    do_op(8'h00, 8'h42, 1'b1, 0, "acc_after_wrap");
  endtask

  task automatic test_accumulate();
    do_op(8'h10, 8'h20, 1'b0, 0, "acc_seed");
    do_op(8'h00, 8'h05, 1'b1, 2, "acc_add");
    do_op(8'h00, 8'hD0, 1'b1, 0, "acc_wrap");
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    send_beat(8'h12, 1'b0);
    send_beat(8'h34, 1'b0);
    repeat (S) begin @(posedge clk); #1; end
    model_acc = 8'h46;
    held = bus.out_sum;
    checks++;
    if (held !== 8'h46) begin
      errors++;
      $display("FAIL bp_result: sum=%h required 46", held);
    end
    bus.in_valid = 1'b1; bus.in_data = 8'hAA; bus.in_acc = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_sum !== held || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.add_a !== 8'h12) begin
        errors++;
        $display("FAIL bp_stall: sum=%h ir=%b ov=%b a=%h required %h 0 1 12",
                 bus.out_sum, bus.in_ready, bus.out_valid, bus.add_a, held);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.add_a !== 8'h12) begin
      errors++;
      $display("FAIL bp_release: busy=%b ov=%b ir=%b a=%h required 0 0 1 12",
               bus.busy, bus.out_valid, bus.in_ready, bus.add_a);
    end
  endtask

  task automatic test_reset_mid();
    send_beat(8'h77, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_acc = 8'h00;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.add_a !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: busy=%b ov=%b a=%h required 0 0 00", bus.busy, bus.out_valid, bus.add_a);
    end
    do_op(8'h00, 8'h09, 1'b1, 0, "acc_after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_accumulate();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
